ctrl_stream_loader: RTL
=======================

Name: ctrl_stream_loader

Overview:
- Writer counterpart to the LUD hardware tester's control-word playback path.
- Accepts a valid/ready stream of CTRL_WIDTH-bit control words from the host and writes them to consecutive addresses of the CTRL_72_4096_sky130A control store, starting at address 0.
- Stops at the first word whose bit 0 (complete bit) is set, which is the terminator.
- Reports done, overflow-error and word count, so the tester can later replay the program.

Parameters:
- ADDR_WIDTH, 12, control-store address width (depth 2^ADDR_WIDTH).
- CTRL_WIDTH, 72, control-word width; bit 0 is the complete bit.

Ports:
- CLK_100  in  1  sole clock.
- RST  in  1  reset: synchronous, active-high (already decided).
- LOAD_START  in  1  single-cycle pulse; begins or restarts a load.
- S_VALID  in  1  host word valid.
- S_DATA  in  CTRL_WIDTH  host control word.
- S_READY  out  1  loader accepts a word this cycle.
- mem_addr  out  ADDR_WIDTH  control-store address.
- mem_din  out  CTRL_WIDTH  control-store write data.
- mem_csb  out  1  control-store chip select, active-low.
- mem_web  out  1  control-store write enable, active-low.
- LOAD_DONE  out  1  terminator written; program is valid.
- LOAD_ERR  out  1  store filled without a terminator.
- word_count  out  ADDR_WIDTH+1  words written in the current or last load.
- debug_state  out  2  present FSM state.

Behaviour:
- Reset (RST=1 at a clock edge) sets every output and register as follows:
  - state IDLE, so debug_state=00.
  - S_READY=0, mem_csb=1, mem_web=1, mem_addr=0, mem_din=0.
  - LOAD_DONE=0, LOAD_ERR=0, word_count=0.
  - RST overrides every other input in that cycle.
- FSM states: IDLE=00, LOAD=01, DONE=10, ERR=11.
- S_READY is decoded from state only: it is 1 only in LOAD.
- Handshake: a word is accepted in any cycle where S_VALID and S_READY are both 1.
  - S_DATA must stay stable while S_VALID=1 and S_READY=0.
  - S_VALID may be asserted at any time; when S_READY=0 it has no effect.
- Write stage is registered. For a word accepted in cycle N, in cycle N+1:
  - mem_csb=0, mem_web=0, mem_addr = write pointer, mem_din = the accepted S_DATA.
  - word_count has incremented.
- In every cycle with no accepted word in the previous cycle: mem_csb=1, mem_web=1, and mem_addr/mem_din hold their last values.
- Write pointer: set to 0 on LOAD_START and increments by 1 after each accepted word.
- word_count is 1 bit wider than the pointer so that a full store reads 2^ADDR_WIDTH.
- IDLE:
  - LOAD_START -> LOAD; clears pointer, word_count, LOAD_DONE and LOAD_ERR.
  - Otherwise stays in IDLE.
- LOAD, per accepted word:
  - Complete bit S_DATA[0]=1 -> DONE. The terminator word is itself written.
  - Else, if pointer = 2^ADDR_WIDTH-1 -> ERR. The word is written; the pointer does not wrap.
  - Else stays in LOAD.
  - With no accepted word, stays in LOAD indefinitely; there is no timeout.
- DONE: LOAD_DONE=1, held until LOAD_START or RST.
- ERR: LOAD_ERR=1, held until LOAD_START or RST.
- LOAD_START in LOAD, DONE or ERR restarts the load: state -> LOAD, pointer and word_count -> 0, flags cleared.
  - Any word offered in that same cycle is not accepted, even from LOAD. LOAD_START has priority over the handshake.
- A terminator in the last slot (pointer = 2^ADDR_WIDTH-1 with bit0=1) -> DONE, not ERR.
- LOAD_DONE/LOAD_ERR change at the same edge as the state register, i.e. in cycle N+1 together with the final write strobe.
  - S_READY is therefore already 0 in cycle N+1.
- Memory arbitration is outside this block. The loader owns the store port only while the tester's START is low; the integrator keeps LOAD_START and START mutually exclusive.

Decomposition:
- Shared package:
  - state encodings ST_IDLE, ST_LOAD, ST_DONE, ST_ERR (2-bit).
  - constant COMPLETE_BIT_IDX=0, also used by the tester.
  - default ADDR_WIDTH/CTRL_WIDTH constants.
- One sub-module, ctrl_wr_port_reg: a registered write stage taking accept, pointer and data, producing mem_csb/mem_web/mem_addr/mem_din with hold-on-idle. The FSM, pointer and counter stay in the top.

Test Plan:
- Reset, then LOAD_START with 3 words 0x...10, 0x...20, 0x...21 (last has bit0=1) presented back-to-back -> writes at addr 0,1,2 on 3 consecutive cycles each one cycle after accept; LOAD_DONE=1 and S_READY=0 in the cycle of the addr-2 write; word_count=3; debug_state=10.
- S_VALID toggled 1/0 every cycle over 4 words, terminator last -> exactly 4 write strobes (mem_web=0), addresses 0..3, no gaps in address; word_count=4.
- ADDR_WIDTH=4, 16 words, none with bit0=1 -> 16 writes addr 0..15, LOAD_ERR=1 after the 16th, debug_state=11, word_count=16, pointer not wrapped; the 17th offered word is not accepted.
- ADDR_WIDTH=4, 15 plain words then terminator -> LOAD_DONE=1, LOAD_ERR=0, word_count=16.
- LOAD_START asserted mid-load after 5 words, with S_VALID=1 in that cycle -> no write in the next cycle; the following accepted word is written to addr 0; word_count restarts at 1.
- RST pulsed during LOAD after 2 words -> next cycle all outputs at reset values; S_VALID is ignored until LOAD_START.

Source files
------------

// File: rtl/ctrl_stream_loader_pkg.sv
// Shared definitions for the control-store loader and the tester that replays it.
//   - state_t          : loader FSM encoding, also exported on debug_state
//   - COMPLETE_BIT_IDX : bit of a control word that marks the last word of a program
//   - DEFAULT_*        : default control-store geometry
package ctrl_stream_loader_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 12;
    localparam int unsigned DEFAULT_CTRL_WIDTH = 72;
    localparam int unsigned COMPLETE_BIT_IDX   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

endpackage

// File: rtl/ctrl_wr_port_reg.sv
// Registered write stage in front of the control-store port.
// A word accepted in one cycle is presented to the store in the next cycle;
// when nothing was accepted the strobes deassert and address/data hold.
//   CLK_100, RST  : clock, synchronous active-high reset
//   accept        : a word was accepted this cycle
//   wr_ptr        : address for the accepted word
//   wr_data       : the accepted word
//   mem_csb/web   : active-low chip select / write enable
//   mem_addr/din  : store address / write data
module ctrl_wr_port_reg #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned CTRL_WIDTH = 72
) (
    input  logic                  CLK_100,
    input  logic                  RST,
    input  logic                  accept,
    input  logic [ADDR_WIDTH-1:0] wr_ptr,
    input  logic [CTRL_WIDTH-1:0] wr_data,
    output logic                  mem_csb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [CTRL_WIDTH-1:0] mem_din
);

    always_ff @(posedge CLK_100) begin
        if (RST) begin
            mem_csb  <= 1'b1;
            mem_web  <= 1'b1;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_csb <= !accept;
            mem_web <= !accept;
            if (accept) begin
                mem_addr <= wr_ptr;
                mem_din  <= wr_data;
            end
        end
    end

endmodule

// File: rtl/ctrl_stream_loader.sv
// Loads a valid/ready stream of control words into the control store from
// address 0 until a word with the complete bit set, flagging an overflow if
// the store fills first.
//   CLK_100, RST         : clock, synchronous active-high reset
//   LOAD_START           : pulse, starts or restarts a load
//   S_VALID/S_DATA       : host word stream
//   S_READY              : high only while loading
//   mem_*                : control-store write port (active-low strobes)
//   LOAD_DONE / LOAD_ERR : terminator written / store filled without one
//   word_count           : words written in the current or last load
//   debug_state          : present FSM state
module ctrl_stream_loader
    import ctrl_stream_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned CTRL_WIDTH = DEFAULT_CTRL_WIDTH
) (
    input  logic                  CLK_100,
    input  logic                  RST,
    input  logic                  LOAD_START,
    input  logic                  S_VALID,
    input  logic [CTRL_WIDTH-1:0] S_DATA,
    output logic                  S_READY,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [CTRL_WIDTH-1:0] mem_din,
    output logic                  mem_csb,
    output logic                  mem_web,
    output logic                  LOAD_DONE,
    output logic                  LOAD_ERR,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [1:0]            debug_state
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  accept_c;

    // LOAD_START wins over a handshake offered in the same cycle
    assign accept_c = S_VALID && S_READY && !LOAD_START;

    // State register
    always_ff @(posedge CLK_100) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (LOAD_START) begin
            next_state = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept_c) begin
                        if (S_DATA[COMPLETE_BIT_IDX]) begin
                            next_state = ST_DONE;
                        end else if (wr_ptr == PTR_LAST) begin
                            next_state = ST_ERR;
                        end
                    end
                end
                default: next_state = state;
            endcase
        end
    end

    // Status outputs registered from next_state so they move with the state
    always_ff @(posedge CLK_100) begin
        if (RST) begin
            S_READY   <= 1'b0;
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
        end else begin
            S_READY   <= (next_state == ST_LOAD);
            LOAD_DONE <= (next_state == ST_DONE);
            LOAD_ERR  <= (next_state == ST_ERR);
        end
    end

    assign debug_state = state;

    // Write pointer and word counter; the pointer stops at the last slot
    always_ff @(posedge CLK_100) begin
        if (RST) begin
            wr_ptr     <= '0;
            word_count <= '0;
        end else if (LOAD_START) begin
            wr_ptr     <= '0;
            word_count <= '0;
        end else if (accept_c) begin
            word_count <= word_count + CNT_WIDTH'(1);
            if (wr_ptr != PTR_LAST) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    ctrl_wr_port_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_wr_port (
        .CLK_100  (CLK_100),
        .RST      (RST),
        .accept   (accept_c),
        .wr_ptr   (wr_ptr),
        .wr_data  (S_DATA),
        .mem_csb  (mem_csb),
        .mem_web  (mem_web),
        .mem_addr (mem_addr),
        .mem_din  (mem_din)
    );

endmodule
